fifo_flags: RTL and testbench
=============================

Name: fifo_flags

Overview:
- Next-generation synchronous FIFO. Single clock domain, parametrised data width and depth.
- Adds over the existing fifo: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and simultaneous read+write when full.
- Sits between producer and consumer blocks as the standard buffering element; drop-in for fifo (same write/read/full/empty semantics).

Parameters:
- D_W, 8, data word width in bits
- AD_W, 4, address width; depth = 2**AD_W words
- AF_LEVEL, 2**AD_W-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-low
- write  in  1  write request
- read  in  1  read request
- err_clr  in  1  synchronous clear of overflow/underflow
- data_in  in  D_W  write data
- data_out  out  D_W  read data
- full  out  1  count == 2**AD_W
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AD_W+1  current occupancy, 0..2**AD_W
- overflow  out  1  sticky: write dropped
- underflow  out  1  sticky: read on empty

Behaviour:
- Storage: 2**AD_W x D_W register array. wr_ptr and rd_ptr are AD_W bits and wrap modulo depth. Memory is not cleared by reset.
- Reset (rst=0, async):
  - Pointers = 0, count = 0, data_out = 0, overflow = 0, underflow = 0.
  - Hence empty=1, almost_empty=1, full=0, almost_full=0.
  - Reset asserted mid-transfer discards contents immediately. First edge after release behaves as from empty.
- Write accept: wr_en = write && (!full || read).
  - On the edge: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accept: rd_en = read && !empty.
  - On the edge: data_out <= mem[rd_ptr], rd_ptr++.
  - Latency: data visible 1 cycle after the accepting edge. data_out holds its value when no read is accepted.
- Count: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither.
- Flags are combinational decodes of the registered count, valid immediately after the edge that changes count.
- Boundary cases:
  - Full, read=1, write=1: both accepted, count stays at depth. data_out gets the old head word; the new word lands in the freed slot.
  - Full, write=1, read=0: write dropped, overflow <= 1.
  - Empty, read=1: read rejected, data_out unchanged, underflow <= 1. This holds even with a simultaneous write; that write is accepted and count -> 1.
  - Pointer wrap 2**AD_W-1 -> 0 is transparent.
- Error flags: stay set until err_clr=1 at an edge. If a new error and err_clr occur in the same cycle, the set wins.
- AF_LEVEL must be in 1..2**AD_W and AE_LEVEL in 0..2**AD_W-1. Out-of-range values are a configuration error; no runtime check is required.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - read acts as an acknowledge: rd_en pops the head, and the next word appears in the same cycle after the edge.
  - Zero-cycle read latency; all other rules unchanged.
- Undefined: registered read, 1-cycle latency as above.

Test Plan (D_W=8, AD_W=4, AF_LEVEL=14, AE_LEVEL=2):
- Reset then write 0x01..0x10 over 16 cycles -> count steps 1..16; almost_empty drops when count=3; almost_full rises at 14; full at 16; overflow=0.
- Full, write 0x11 with read=0 -> write dropped, count=16, overflow=1. Then read 16 words -> data_out 0x01..0x10 in order, 1 cycle after each read; empty=1 after last.
- Full, read=1 and write=1 with data 0xAA for 1 cycle -> count stays 16, data_out=0x01. After 16 further reads the last word out = 0xAA.
- Empty, read=1 and write=1 with 0x55 -> underflow=1, count=1, data_out unchanged. err_clr pulse -> underflow=0, overflow=0.
- 40 mixed writes/reads wrapping pointers twice -> output order matches a scoreboard; count never exceeds 16.
- Write 5 words, assert rst=0 between clock edges -> count=0, empty=1, data_out=0 without waiting for an edge. After release, write 0x77 then read -> data_out=0x77.
- With FIFO_FWFT_EN, write 0x01, 0x02 -> data_out=0x01 while read=0. Pulse read -> data_out=0x02 immediately after the edge.

Source files
------------

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_flags #(
    parameter int D_W      = 8,
    parameter int AD_W     = 4,
    parameter int AF_LEVEL = 2**AD_W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic            read,
    input  logic            err_clr,
    input  logic [D_W-1:0]  data_in,
    output logic [D_W-1:0]  data_out,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [AD_W:0]   count,
    output logic            overflow,
    output logic            underflow
);

    localparam int DEPTH = 2**AD_W;
    localparam logic [AD_W-1:0] PTR_ONE = 1;
    localparam logic [AD_W:0]   CNT_ONE = 1;

    logic [D_W-1:0]  mem_q [DEPTH];
    logic [AD_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [AD_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [AD_W:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            wr_en, rd_en;

    assign full         = (count_q == (AD_W+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= (AD_W+1)'(AF_LEVEL));
    assign almost_empty = (count_q <= (AD_W+1)'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign rd_en = read && !empty;
    assign wr_en = write && (!full || read);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_en && !rd_en)
            count_d = count_q + CNT_ONE;
        else if (rd_en && !wr_en)
            count_d = count_q - CNT_ONE;
        ovf_d = (write && full && !read) || (ovf_q && !err_clr);
        udf_d = (read && empty) || (udf_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [D_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout_q <= '0;
        else if (rd_en)
            dout_q <= mem_q[rd_ptr_q];
    end

    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Scoreboard bench for fifo_flags: queue-based reference model plus directed
// boundary cases and randomized traffic.
module tb_fifo_flags;

    logic       clk;
    logic       rst;
    logic       write;
    logic       read;
    logic       err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    fifo_flags #(
        .D_W(8), .AD_W(4), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .read(read),
        .err_clr(err_clr), .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic       m_udf;
    logic       rd_fire;
    logic [7:0] last_out;
    bit         ra, wa, newo, newu;
    logic [7:0] hw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst) begin
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rd_fire = 1'b0;
        last_out = 8'h00;
    end

    // Reference model: FIFO as a queue, flags from its size.
    always @(posedge clk) begin
        rd_fire = 1'b0;
        if (rst) begin
            ra   = read && mq.size() != 0;
            wa   = write && (mq.size() < 16 || read);
            newo = write && !read && mq.size() == 16;
            newu = read && mq.size() == 0;
            if (ra) begin
                hw = mq.pop_front();
`ifndef FIFO_FWFT_EN
                exp_q.push_back(hw);
                rd_fire = 1'b1;
`endif
            end
            if (wa)
                mq.push_back(data_in);
            m_ovf = newo || (m_ovf && !err_clr);
            m_udf = newu || (m_udf && !err_clr);
        end
    end

    // Monitor: pops the scoreboard when a read result is due.
    always @(posedge clk) begin
        #1;
        if (rst) begin
`ifdef FIFO_FWFT_EN
            chk("fwft_data", data_out, mq.size() != 0 ? mq[0] : 0);
`else
            if (rd_fire) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underrun", 1, 0);
                end else begin
                    last_out = exp_q.pop_front();
                    chk("read_data", data_out, last_out);
                end
            end else begin
                chk("data_hold", data_out, last_out);
            end
`endif
            chk("count", count, mq.size());
            chk("count_max", int'(count <= 5'd16), 1);
            chk("full", full, mq.size() == 16);
            chk("empty", empty, mq.size() == 0);
            chk("almost_full", almost_full, mq.size() >= 14);
            chk("almost_empty", almost_empty, mq.size() <= 2);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_udf);
        end
    end

    task automatic step(input logic w, input logic r,
                        input logic [7:0] d, input logic c);
        write   = w;
        read    = r;
        data_in = d;
        err_clr = c;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        write = 1'b0;
        read = 1'b0;
        err_clr = 1'b0;
        data_in = 8'h00;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic w, r;
            int ph;
            ph = (i / 50) % 2;
            w = ($urandom_range(0, 99) < (ph == 0 ? 75 : 35));
            r = ($urandom_range(0, 99) < (ph == 0 ? 35 : 75));
            step(w, r, 8'($urandom), ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        write = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_dout", data_out, 0);
        chk("arst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h77, 1'b0);
`ifdef FIFO_FWFT_EN
        step(1'b1, 1'b0, 8'h78, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft_head", data_out, 8'h77);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("fwft_next", data_out, 8'h78);
`endif
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
`ifndef FIFO_FWFT_EN
        chk("post_rst_read", data_out, 8'h77);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
